vreq_sequencer: RTL
===================

Name: vreq_sequencer

Overview:
Downstream consumer of the 32-bit descriptor FIFO in the vector memory path. Pops one vector-access descriptor at a time (base address, element count, stride). Expands it into a sequence of per-element memory requests on a valid/ready interface. Reports completion per descriptor.

Parameters:
WIDTH, 32, FIFO entry width; descriptor layout fixed as addr[31:16], len[15:8], stride[7:0]
ADDR_W, 16, memory request address width
LEN_W, 8, element-count width
CNT_W, 16, completed-descriptor counter width

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  descriptor FIFO empty flag
fifo_rsp_data  input  WIDTH  FIFO head entry (combinational, valid while !fifo_empty)
fifo_rsp  output  1  pop strobe to FIFO; one cycle per descriptor
mem_req_valid  output  1  element request valid
mem_req_addr  output  ADDR_W  element address
mem_req_idx  output  LEN_W  element index within descriptor, 0-based
mem_req_last  output  1  high with the final element of a descriptor
mem_req_ready  input  1  memory side accepts request
busy  output  1  high when state != IDLE
desc_done  output  1  one-cycle pulse per completed descriptor
desc_cnt  output  CNT_W  completed descriptors, wraps at 2^CNT_W

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-high (reset). Reset forces state=IDLE and clears all registers.
- Reset values: mem_req_valid=0, mem_req_addr=0, mem_req_idx=0, mem_req_last=0, busy=0, desc_done=0, desc_cnt=0.
- fifo_rsp is combinational: (state==IDLE) && !fifo_empty && !reset. It is 0 while reset is asserted.
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - If !fifo_empty: fifo_rsp=1. Capture base/len/stride from fifo_rsp_data on the same edge; clear idx.
  - If len!=0: go to ISSUE.
  - If len==0: stay in IDLE; desc_done pulses next cycle and desc_cnt increments. No memory request is issued.
- ISSUE:
  - mem_req_valid=1. mem_req_addr=current address. mem_req_idx=idx. mem_req_last=(idx==len-1).
  - Handshake occurs when valid && ready.
  - No handshake: addr, idx and last hold stable. valid never drops before the handshake.
  - Handshake, not last: addr <= addr + sign_extend(stride) mod 2^ADDR_W; idx <= idx+1.
  - Handshake, last: go to IDLE. mem_req_valid=0 next cycle. desc_done=1 for exactly that next cycle. desc_cnt increments on that same edge.
- Stride arithmetic:
  - stride is 8-bit two's complement, sign-extended to ADDR_W.
  - Address wraps modulo 2^ADDR_W in both directions. No error is flagged.
- len=255 produces 255 requests. len=0 is a no-op descriptor.
- Latency:
  - Pop to first mem_req_valid is 1 cycle.
  - Last handshake to next pop is 1 cycle, spent in IDLE. The bubble cycle between descriptors is required.
- fifo_empty rising while in ISSUE has no effect.
- Reset mid-ISSUE: the descriptor in flight is discarded and not counted, even though it was already popped. mem_req_valid drops asynchronously.
- desc_done and fifo_rsp can both be high in the same cycle (completion of one descriptor plus pop of the next).

Test Plan:
- Reset: hold reset with FIFO non-empty -> fifo_rsp=0, all outputs 0, busy=0; after release, first pop happens on the first IDLE cycle.
- Basic descriptor {addr=0x1000,len=4,stride=4}, ready=1 -> fifo_rsp high 1 cycle; valid on 4 consecutive cycles with addr 0x1000/0x1004/0x1008/0x100C, idx 0..3, last only on 0x100C; desc_done 1 cycle later; desc_cnt=1.
- Backpressure: same descriptor, ready=0 for 3 cycles while at idx1 -> addr held 0x1004 and valid held for 4 cycles; total sequence unchanged; desc_cnt=1.
- Negative stride with wrap {addr=0x0002,len=3,stride=0xFE} -> addrs 0x0002, 0x0000, 0xFFFE; last on 0xFFFE.
- Zero length {addr=0x2000,len=0} followed by {addr=0x3000,len=1,stride=0} -> no request for the first; desc_done pulse; then single request 0x3000 with last=1; desc_cnt=2.
- Back-to-back plus reset: two descriptors queued -> exactly one idle cycle between last of #1 and valid of #2; asserting reset during #2 at idx1 -> valid drops immediately, desc_cnt stays 1, and next descriptor starts from a fresh pop.

Source files
------------

// File: rtl/vreq_sequencer.sv
// vreq_sequencer: pops vector-access descriptors (base, length, stride) from
// the descriptor FIFO and expands each one into a stream of per-element
// memory requests on a valid/ready interface, pulsing desc_done and counting
// every descriptor that runs to completion.
module vreq_sequencer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_rsp_data,
  output logic              fifo_rsp,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LEN_W-1:0]  mem_req_idx,
  output logic              mem_req_last,
  input  logic              mem_req_ready,
  output logic              busy,
  output logic              desc_done,
  output logic [CNT_W-1:0]  desc_cnt
);

  // Descriptor field positions inside a FIFO entry: addr | len | stride.
  localparam int STRIDE_W = 8;
  localparam int LEN_LSB  = STRIDE_W;
  localparam int ADDR_LSB = LEN_LSB + LEN_W;

  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                state;
  logic [LEN_W-1:0]      len_reg;
  logic [STRIDE_W-1:0]   stride_reg;

  // Decoded head-of-FIFO fields (only meaningful while !fifo_empty).
  logic [ADDR_W-1:0]     head_addr;
  logic [LEN_W-1:0]      head_len;
  logic [STRIDE_W-1:0]   head_stride;

  // Next-element bookkeeping used on an accepted, non-final request.
  logic [ADDR_W-1:0]     stride_ext;
  logic [LEN_W-1:0]      idx_next;
  logic [LEN_W-1:0]      len_m1;

  assign head_addr   = fifo_rsp_data[ADDR_LSB +: ADDR_W];
  assign head_len    = fifo_rsp_data[LEN_LSB +: LEN_W];
  assign head_stride = fifo_rsp_data[STRIDE_W-1:0];

  // Stride is two's complement; sign extension plus modulo addition gives
  // wrap-around in both directions with no overflow flag.
  assign stride_ext = {{(ADDR_W-STRIDE_W){stride_reg[STRIDE_W-1]}}, stride_reg};
  assign idx_next   = mem_req_idx + LEN_ONE;
  assign len_m1     = len_reg - LEN_ONE;

  // Pop strobe: combinational so the descriptor is consumed on the same edge
  // it is captured; forced low while reset is held.
  always_comb begin
    fifo_rsp = (state == IDLE) && !fifo_empty && !reset;
  end

  assign busy = (state != IDLE);

  // Sequencer FSM with registered request/completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len_reg       <= '0;
      stride_reg    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_idx   <= '0;
      mem_req_last  <= 1'b0;
      desc_done     <= 1'b0;
      desc_cnt      <= '0;
    end else begin
      desc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            len_reg      <= head_len;
            stride_reg   <= head_stride;
            mem_req_addr <= head_addr;
            mem_req_idx  <= '0;
            if (head_len != '0) begin
              state         <= ISSUE;
              mem_req_valid <= 1'b1;
              mem_req_last  <= (head_len == LEN_ONE);
            end else begin
              // Empty descriptor: completes immediately without any request.
              desc_done <= 1'b1;
              desc_cnt  <= desc_cnt + CNT_ONE;
            end
          end
        end
        ISSUE: begin
          // valid is always high here, so ready alone marks the handshake.
          if (mem_req_ready) begin
            if (mem_req_last) begin
              state         <= IDLE;
              mem_req_valid <= 1'b0;
              mem_req_last  <= 1'b0;
              desc_done     <= 1'b1;
              desc_cnt      <= desc_cnt + CNT_ONE;
            end else begin
              mem_req_addr <= mem_req_addr + stride_ext;
              mem_req_idx  <= idx_next;
              mem_req_last <= (idx_next == len_m1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
